// File: rtl/trace_pkg.sv
// Shared types for the trace stream decoder: word-type bit location,
// record kind and output-stage state.
package trace_pkg;

  typedef enum logic {DATA = 1'b0, DROP = 1'b1} rec_t;
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} ostate_t;

  // The record-type flag sits just above the sample field.
  function automatic int type_bit(input int sample_width);
    return sample_width;
  endfunction

endpackage

// File: rtl/trace_unpacker_sat_accumulator.sv
// Saturating accumulator register with async active-low clear.
// Adds i_add_dat when i_add_vld, sticking at all-ones instead of wrapping.
module sat_accumulator #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_add_vld,
  input  logic [W-1:0] i_add_dat,
  output logic [W-1:0] o_sum_dat
);

  logic [W-1:0] r_sum;
  logic [W:0]   w_sum;

  assign w_sum     = {1'b0, r_sum} + {1'b0, i_add_dat};
  assign o_sum_dat = r_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum <= '0;
    end else if (i_add_vld) begin
      r_sum <= w_sum[W] ? '1 : w_sum[W-1:0];
    end
  end

endmodule

// File: rtl/trace_unpacker.sv
// Decodes data/drop-record FIFO words into sequenced samples with gap flags,
// through a 1-entry output register; fifo_ready passes sample_ready_i through.
module trace_unpacker
  import trace_pkg::*;
#(
  parameter int sample_width_p  = 4,
  parameter int counter_width_p = 4,
  parameter int seq_width_p     = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [sample_width_p:0]   fifo_data,
  input  logic                      fifo_valid,
  output logic                      fifo_ready,
  output logic [sample_width_p-1:0] sample_data_o,
  output logic                      sample_valid_o,
  input  logic                      sample_ready_i,
  output logic [seq_width_p-1:0]    sample_seq_o,
  output logic                      sample_gap_o,
  output logic [seq_width_p-1:0]    drop_total_o,
  output logic                      drop_sat_o
);

  localparam int TypeBit = type_bit(sample_width_p);
  localparam logic [seq_width_p-1:0] SeqOne = 1;

  ostate_t                   r_state;
  logic [sample_width_p-1:0] r_data;
  logic [seq_width_p-1:0]    r_seq_o;
  logic                      r_gap_o;
  logic [seq_width_p-1:0]    r_seq;
  logic                      r_gap_pend;
  logic                      r_sat;

  rec_t                       w_type;
  logic                       w_accept;
  logic                       w_acc_data;
  logic                       w_acc_drop;
  logic [counter_width_p-1:0] w_cnt;
  logic [seq_width_p-1:0]     w_n;

  assign w_type     = rec_t'(fifo_data[TypeBit]);
  assign fifo_ready = (r_state == EMPTY) | sample_ready_i;
  assign w_accept   = fifo_valid & fifo_ready;
  assign w_acc_data = w_accept & (w_type == DATA);
  assign w_acc_drop = w_accept & (w_type == DROP);
  assign w_cnt      = fifo_data[counter_width_p-1:0];

  always_comb begin
    w_n = '0;
    w_n[counter_width_p-1:0] = w_cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= EMPTY;
      r_data     <= '0;
      r_seq_o    <= '0;
      r_gap_o    <= 1'b0;
      r_seq      <= '0;
      r_gap_pend <= 1'b0;
      r_sat      <= 1'b0;
    end else begin
      if (w_acc_data) begin
        r_state    <= FULL;
        r_data     <= fifo_data[sample_width_p-1:0];
        r_seq_o    <= r_seq;
        r_gap_o    <= r_gap_pend;
        r_seq      <= r_seq + SeqOne;
        r_gap_pend <= 1'b0;
      end else if (sample_ready_i) begin
        r_state <= EMPTY;
      end
      // A drop record never coincides with a data accept, so seq updates don't collide.
      if (w_acc_drop) begin
        r_seq <= r_seq + w_n;
        if (w_cnt != '0) r_gap_pend <= 1'b1;
        if (&w_cnt)      r_sat      <= 1'b1;
      end
    end
  end

  sat_accumulator #(.W(seq_width_p)) u_drop_total (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_add_vld (w_acc_drop),
    .i_add_dat (w_n),
    .o_sum_dat (drop_total_o)
  );

  assign sample_valid_o = (r_state == FULL);
  assign sample_data_o  = r_data;
  assign sample_seq_o   = r_seq_o;
  assign sample_gap_o   = r_gap_o;
  assign drop_sat_o     = r_sat;

endmodule

// File: tb/tb_trace_unpacker.sv
// Drives a 16-bit-seq and a 4-bit-seq decoder from one stream and scores both
// against a behavioural model with an expected-sample queue.
module tb_trace_unpacker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] fifo_data = '0;
  logic       fifo_valid = 1'b0;
  logic       sample_ready_i = 1'b0;

  logic        fifo_ready, fifo_ready_n;
  logic [3:0]  sample_data_o, sample_data_n;
  logic        sample_valid_o, sample_valid_n;
  logic [15:0] sample_seq_o;
  logic [3:0]  sample_seq_n;
  logic        sample_gap_o, sample_gap_n;
  logic [15:0] drop_total_o;
  logic [3:0]  drop_total_n;
  logic        drop_sat_o, drop_sat_n;

  always #5 clk = ~clk;

  trace_unpacker u_dut (
    .clk(clk), .rst_n(rst_n), .fifo_data(fifo_data), .fifo_valid(fifo_valid),
    .fifo_ready(fifo_ready), .sample_data_o(sample_data_o), .sample_valid_o(sample_valid_o),
    .sample_ready_i(sample_ready_i), .sample_seq_o(sample_seq_o), .sample_gap_o(sample_gap_o),
    .drop_total_o(drop_total_o), .drop_sat_o(drop_sat_o)
  );

  trace_unpacker #(.seq_width_p(4)) u_dut_n (
    .clk(clk), .rst_n(rst_n), .fifo_data(fifo_data), .fifo_valid(fifo_valid),
    .fifo_ready(fifo_ready_n), .sample_data_o(sample_data_n), .sample_valid_o(sample_valid_n),
    .sample_ready_i(sample_ready_i), .sample_seq_o(sample_seq_n), .sample_gap_o(sample_gap_n),
    .drop_total_o(drop_total_n), .drop_sat_o(drop_sat_n)
  );

  typedef struct {
    logic [3:0]  data;
    logic [15:0] seq;
    logic        gap;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  logic        m_full;
  logic [15:0] m_seq;
  logic        m_gap;
  int          m_tot_w;
  int          m_tot_n;
  logic        m_sat;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model runs on the falling edge: compare current outputs, then apply this cycle's handshakes.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_full = 1'b0; m_seq = '0; m_gap = 1'b0;
      m_tot_w = 0; m_tot_n = 0; m_sat = 1'b0;
      q.delete();
    end else begin
      logic       exp_rdy;
      logic       acc;
      logic [3:0] n;
      exp_rdy = !m_full | sample_ready_i;
      chk("fifo_ready", {31'd0, fifo_ready}, {31'd0, exp_rdy});
      chk("fifo_ready_n", {31'd0, fifo_ready_n}, {31'd0, exp_rdy});
      chk("valid", {31'd0, sample_valid_o}, {31'd0, m_full});
      chk("valid_n", {31'd0, sample_valid_n}, {31'd0, m_full});
      chk("drop_total", {16'd0, drop_total_o}, m_tot_w);
      chk("drop_total_n", {28'd0, drop_total_n}, m_tot_n);
      chk("drop_sat", {31'd0, drop_sat_o}, {31'd0, m_sat});
      chk("drop_sat_n", {31'd0, drop_sat_n}, {31'd0, m_sat});
      if (m_full) begin
        if (q.size() == 0) begin
          chk("queue_underflow", 32'd1, 32'd0);
        end else begin
          chk("data", {28'd0, sample_data_o}, {28'd0, q[0].data});
          chk("seq", {16'd0, sample_seq_o}, {16'd0, q[0].seq});
          chk("gap", {31'd0, sample_gap_o}, {31'd0, q[0].gap});
          chk("data_n", {28'd0, sample_data_n}, {28'd0, q[0].data});
          chk("seq_n", {28'd0, sample_seq_n}, {28'd0, q[0].seq[3:0]});
          chk("gap_n", {31'd0, sample_gap_n}, {31'd0, q[0].gap});
          if (sample_ready_i) void'(q.pop_front());
        end
      end
      acc = fifo_valid & exp_rdy;
      n = fifo_data[3:0];
      if (acc && !fifo_data[4]) begin
        q.push_back('{data: fifo_data[3:0], seq: m_seq, gap: m_gap});
        m_seq = m_seq + 16'd1;
        m_gap = 1'b0;
      end else if (acc) begin
        m_seq   = m_seq + {12'd0, n};
        m_tot_w = (m_tot_w + n > 65535) ? 65535 : m_tot_w + n;
        m_tot_n = (m_tot_n + n > 15) ? 15 : m_tot_n + n;
        if (n != 0) m_gap = 1'b1;
        if (n == 4'hF) m_sat = 1'b1;
      end
      m_full = (acc && !fifo_data[4]) | (m_full & !sample_ready_i);
    end
  end

  task automatic drive(input logic v, input logic [4:0] d, input logic rdy);
    fifo_valid     = v;
    fifo_data      = d;
    sample_ready_i = rdy;
    @(posedge clk);
    #1;
  endtask

  // Reset takes effect asynchronously; outputs must clear before any clock edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_valid", {30'd0, sample_valid_o, sample_valid_n}, 32'd0);
    chk("rst_data", {24'd0, sample_data_o, sample_data_n}, 32'd0);
    chk("rst_seq", {12'd0, sample_seq_o, sample_seq_n}, 32'd0);
    chk("rst_gap", {30'd0, sample_gap_o, sample_gap_n}, 32'd0);
    chk("rst_total", {12'd0, drop_total_o, drop_total_n}, 32'd0);
    chk("rst_sat", {30'd0, drop_sat_o, drop_sat_n}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
    repeat (3) drive(1'b0, 5'h00, 1'b0);

    // Back-to-back data with downstream always ready.
    drive(1'b1, 5'h01, 1'b1);
    drive(1'b1, 5'h02, 1'b1);
    drive(1'b1, 5'h03, 1'b1);
    repeat (2) drive(1'b0, 5'h00, 1'b1);

    do_reset();
    drive(1'b1, 5'h05, 1'b1);
    drive(1'b1, 5'h13, 1'b1);
    drive(1'b1, 5'h09, 1'b1);
    repeat (2) drive(1'b0, 5'h00, 1'b1);

    do_reset();
    drive(1'b1, 5'h12, 1'b1);
    drive(1'b1, 5'h1F, 1'b1);
    drive(1'b1, 5'h0A, 1'b1);
    drive(1'b1, 5'h10, 1'b1);
    drive(1'b1, 5'h0B, 1'b1);
    drive(1'b0, 5'h00, 1'b1);
    chk("tp4_total", {16'd0, drop_total_o}, 32'd17);
    chk("tp4_sat", {31'd0, drop_sat_o}, 32'd1);

    // Stall with a word waiting: it must be neither lost nor duplicated.
    drive(1'b1, 5'h07, 1'b1);
    repeat (3) drive(1'b1, 5'h08, 1'b0);
    drive(1'b1, 5'h08, 1'b1);
    drive(1'b1, 5'h13, 1'b0);
    drive(1'b1, 5'h13, 1'b1);
    drive(1'b1, 5'h0C, 1'b1);
    repeat (2) drive(1'b0, 5'h00, 1'b1);

    do_reset();
    for (int i = 0; i < 18; i++) drive(1'b1, {1'b0, 4'(i)}, 1'b1);
    drive(1'b1, 5'h1F, 1'b1);
    drive(1'b1, 5'h15, 1'b1);
    drive(1'b1, 5'h06, 1'b1);
    drive(1'b0, 5'h00, 1'b1);
    chk("narrow_total_sat", {28'd0, drop_total_n}, 32'd15);
    chk("wide_total", {16'd0, drop_total_o}, 32'd20);

    // Reset while holding a stalled sample.
    drive(1'b1, 5'h03, 1'b1);
    drive(1'b0, 5'h00, 1'b0);
    do_reset();
    repeat (2) drive(1'b0, 5'h00, 1'b1);

    drive(1'b1, 5'h04, 1'b1);
    for (int i = 0; i < 20 && m_full; i++) drive(1'b0, 5'h00, 1'b1);
    chk("drain_full", {31'd0, m_full}, 32'd0);
    chk("drain_queue", q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
